// File: rtl/sel_sorter_param.sv
// sel_sorter_param: in-place ascending/descending selection sorter over a DEPTH x WIDTH RAM.
// Define SORT_SWAP_CNT_EN to add the swap_cnt output (swaps made by the last sort).
module sel_sorter_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              desc,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  datain,
    output logic [WIDTH-1:0]  dataout,
`ifdef SORT_SWAP_CNT_EN
    output logic [ADDR_W-1:0] swap_cnt,
`endif
    output logic              ready,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, OUTER, INNER, ENDIN, SWAP_A, SWAP_B} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, idx_q, idx_d, idx_fin;
    logic mode_q, mode_d, ready_q, ready_d, done_q, done_d;
    logic [WIDTH-1:0] best_q, best_d, cur_q, cur_d, rdata_q, rdata_d, dataout_q, dataout_d;
    logic better, first, last_i, advance;
    logic [WIDTH-1:0] mem [DEPTH];
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rword;
`ifdef SORT_SWAP_CNT_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    assign swap_cnt = cnt_q;
`endif

    assign mem_rword = mem[mem_addr];

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        best_d    = best_q;
        cur_d     = cur_q;
        rdata_d   = rdata_q;
        dataout_d = dataout_q;
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = datain;
        advance   = 1'b0;
`ifdef SORT_SWAP_CNT_EN
        cnt_d     = cnt_q;
`endif
        // rdata_q always holds the word read in the previous cycle
        better  = mode_q ? (rdata_q > best_q) : (rdata_q < best_q);
        first   = j_q == i_q + 1'b1;
        last_i  = i_q == ADDR_W'(DEPTH - 2);
        idx_fin = better ? j_q : idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = OUTER;
                    i_d     = '0;
                    mode_d  = desc;
                    ready_d = 1'b0;
`ifdef SORT_SWAP_CNT_EN
                    cnt_d   = '0;
`endif
                end else if (wr) begin
                    mem_we = 1'b1;
                end else if (rd) begin
                    dataout_d = mem_rword;
                end
            end
            OUTER: begin
                mem_addr = i_q;
                rdata_d  = mem_rword;
                j_d      = i_q + 1'b1;
                idx_d    = i_q;
                state_d  = INNER;
            end
            INNER: begin
                mem_addr = j_q;
                rdata_d  = mem_rword;
                if (first) begin
                    best_d = rdata_q;
                    cur_d  = rdata_q;
                end else if (better) begin
                    best_d = rdata_q;
                    idx_d  = j_q - 1'b1;
                end
                if (j_q == ADDR_W'(DEPTH - 1)) state_d = ENDIN;
                else j_d = j_q + 1'b1;
            end
            ENDIN: begin
                idx_d  = idx_fin;
                best_d = better ? rdata_q : best_q;
                if (idx_fin != i_q) state_d = SWAP_A;
                else advance = 1'b1;
            end
            SWAP_A: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = cur_q;
                state_d   = SWAP_B;
            end
            SWAP_B: begin
                mem_we    = 1'b1;
                mem_addr  = i_q;
                mem_wdata = best_q;
                advance   = 1'b1;
`ifdef SORT_SWAP_CNT_EN
                cnt_d     = cnt_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            i_d     = i_q + 1'b1;
            state_d = last_i ? IDLE : OUTER;
            ready_d = last_i;
            done_d  = last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            dataout_q <= '0;
`ifdef SORT_SWAP_CNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            dataout_q <= dataout_d;
            i_q       <= i_d;
            j_q       <= j_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            best_q    <= best_d;
            cur_q     <= cur_d;
            rdata_q   <= rdata_d;
`ifdef SORT_SWAP_CNT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // a reset landing on a swap cycle must not complete the write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
    end

    assign dataout = dataout_q;
    assign ready   = ready_q;
    assign done    = done_q;
endmodule

// File: tb/tb_sel_sorter_param.sv
// tb_sel_sorter_param: randomized self-checking bench for sel_sorter_param (8x8 and 4x16 instances).
module tb_sel_sorter_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic a_start = 0, a_desc = 0, a_wr = 0, a_rd = 0;
    logic [2:0] a_addr = 0;
    logic [7:0] a_din = 0, a_dout;
    logic a_ready, a_done;
    logic b_start = 0, b_desc = 0, b_wr = 0, b_rd = 0;
    logic [1:0] b_addr = 0;
    logic [15:0] b_din = 0, b_dout;
    logic b_ready, b_done;
`ifdef SORT_SWAP_CNT_EN
    logic [2:0] a_sc;
    logic [1:0] b_sc;
`endif

    sel_sorter_param u_a (
        .clk(clk), .rst(rst), .start(a_start), .desc(a_desc), .wr(a_wr), .rd(a_rd),
        .addr(a_addr), .datain(a_din), .dataout(a_dout),
`ifdef SORT_SWAP_CNT_EN
        .swap_cnt(a_sc),
`endif
        .ready(a_ready), .done(a_done));

    sel_sorter_param #(.WIDTH(16), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .desc(b_desc), .wr(b_wr), .rd(b_rd),
        .addr(b_addr), .datain(b_din), .dataout(b_dout),
`ifdef SORT_SWAP_CNT_EN
        .swap_cnt(b_sc),
`endif
        .ready(b_ready), .done(b_done));

    int n_chk = 0, n_fail = 0;
    int ref_mem[8];
    int ref_s;
    int a_exp = 0, b_exp = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // textbook selection sort: strict compare, swap only when a better word was found
    function automatic void model_sort(int n, bit d);
        ref_s = 0;
        for (int i = 0; i < n - 1; i++) begin
            int k = i;
            for (int j = i + 1; j < n; j++)
                if (d ? ref_mem[j] > ref_mem[k] : ref_mem[j] < ref_mem[k]) k = j;
            if (k != i) begin
                int t = ref_mem[i];
                ref_mem[i] = ref_mem[k];
                ref_mem[k] = t;
                ref_s++;
            end
        end
    endfunction

    task automatic set_in(bit s, bit st, bit d, bit w, bit r, int ad, int di);
        if (s) begin
            b_start = st; b_desc = d; b_wr = w; b_rd = r; b_addr = ad[1:0]; b_din = di[15:0];
        end else begin
            a_start = st; a_desc = d; a_wr = w; a_rd = r; a_addr = ad[2:0]; a_din = di[7:0];
        end
    endtask

    task automatic wr_word(bit s, int ad, int v);
        @(negedge clk); set_in(s, 0, 0, 1, 0, ad, v);
        @(negedge clk); set_in(s, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_chk(bit s, int ad, int exp, string tag);
        @(negedge clk); set_in(s, 0, 0, 0, 1, ad, 0);
        @(negedge clk); set_in(s, 0, 0, 0, 0, 0, 0);
        check(tag, s ? 32'(b_dout) : 32'(a_dout), exp);
        if (s) b_exp = exp; else a_exp = exp;
    endtask

    task automatic load(bit s, int n, int v[8]);
        for (int k = 0; k < n; k++) begin
            wr_word(s, k, v[k]);
            ref_mem[k] = v[k];
        end
    endtask

    // inj: pokes wr/rd/start mid-sort; ws: asserts wr together with start
    task automatic sort_chk(bit s, int n, bit d, bit inj, bit ws, string tag);
        int cyc = 0, dones = 0;
        model_sort(n, d);
        @(negedge clk); set_in(s, 1, d, ws, 0, 0, 'h1234);
        @(negedge clk); set_in(s, 0, 0, 0, 0, 0, 0);
        while ((s ? b_ready : a_ready) == 1'b0 && cyc < 1000) begin
            cyc++;
            if (s ? b_done : a_done) dones++;
            if (inj && cyc == 5) set_in(s, 1, ~d, 1, 1, 0, 'hAA);
            else set_in(s, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        set_in(s, 0, 0, 0, 0, 0, 0);
        check({tag, "_latency"}, cyc, 2 * (n - 1) + n * (n - 1) / 2 + 2 * ref_s);
        check({tag, "_done_busy"}, dones, 0);
        check({tag, "_done"}, s ? b_done : a_done, 1);
        check({tag, "_dout_hold"}, s ? 32'(b_dout) : 32'(a_dout), s ? b_exp : a_exp);
`ifdef SORT_SWAP_CNT_EN
        check({tag, "_swap_cnt"}, s ? 32'(b_sc) : 32'(a_sc), ref_s);
`endif
        @(negedge clk);
        check({tag, "_done_clear"}, s ? b_done : a_done, 0);
        for (int k = 0; k < n; k++) rd_chk(s, k, ref_mem[k], $sformatf("%s_rd%0d", tag, k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v[8];
        repeat (3) @(negedge clk);
        check("rst_ready", a_ready, 1);
        check("rst_done", a_done, 0);
        check("rst_dout", a_dout, 0);
        check("rst_b_ready", b_ready, 1);
        rst = 1'b0;

        load(0, 8, '{1, 2, 3, 4, 5, 6, 7, 8});
        sort_chk(0, 8, 0, 0, 0, "t1");
        load(0, 8, '{8, 7, 6, 5, 4, 3, 2, 1});
        sort_chk(0, 8, 0, 0, 0, "t2");
        load(0, 8, '{3, 9, 3, 0, 255, 9, 1, 0});
        sort_chk(0, 8, 1, 0, 0, "t3");

        // wr beats rd in the same idle cycle
        @(negedge clk); set_in(0, 0, 0, 1, 1, 2, 'h5A);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
        check("wr_over_rd_dout", a_dout, a_exp);
        rd_chk(0, 2, 'h5A, "wr_over_rd_data");

        for (int k = 0; k < 8; k++) v[k] = $urandom_range(0, 255);
        load(0, 8, v);
        rd_chk(0, 3, v[3], "t4_pre");
        sort_chk(0, 8, $urandom_range(0, 1), 1, 0, "t4");

        load(0, 8, '{8, 7, 6, 5, 4, 3, 2, 1});
        rd_chk(0, 0, 8, "t5_pre");
        @(negedge clk); set_in(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_ready", a_ready, 1);
        check("t5_done", a_done, 0);
        check("t5_dout", a_dout, 0);
        rst = 1'b0;
        a_exp = 0;
        for (int k = 0; k < 8; k++) v[k] = $urandom_range(0, 255);
        load(0, 8, v);
        sort_chk(0, 8, 0, 0, 0, "t5_post");

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) v[k] = (r % 2) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            load(0, 8, v);
            sort_chk(0, 8, $urandom_range(0, 1), 0, 0, $sformatf("rnd%0d", r));
        end

        load(1, 4, '{'h8000, 'h0001, 'hFFFF, 'h7FFF, 0, 0, 0, 0});
        sort_chk(1, 4, 0, 0, 1, "t6");
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) v[k] = $urandom_range(0, 65535);
            load(1, 4, v);
            sort_chk(1, 4, 1'(r), 0, 0, $sformatf("b_rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sel_sorter_param.md
Name: sel_sorter_param

Overview:
Parametrised in-place selection sorter. It holds a DEPTH x WIDTH single-port-style RAM that the host loads and reads back while the block is idle. On start, the block sorts the RAM ascending or descending. It is the generalised successor of the fixed 8x8 ascending sorter, adding width, depth, sort direction, an explicit read strobe and a done pulse.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of words; power of two, >=2
ADDR_W, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin sort; sampled only while ready=1
desc  in  1  0 = ascending, 1 = descending; latched with start
wr  in  1  host write strobe; honoured only while ready=1
rd  in  1  host read strobe; honoured only while ready=1
addr  in  ADDR_W  host read/write address
datain  in  WIDTH  host write data
dataout  out  WIDTH  host read data, registered
ready  out  1  1 = idle, accepting host ops/start
done  out  1  one-cycle pulse when a sort completes

Behaviour:
- Reset: state=IDLE, ready=1, done=0, dataout=0. RAM contents are not cleared.
- Reset mid-sort aborts the sort on the next edge. RAM is left partially sorted; no done pulse.
- Comparison is unsigned. Ascending selects strict-less; descending selects strict-greater. On ties the earliest index is kept, so equal values never trigger a swap.
- Host ops while IDLE:
  - wr: mem[addr]<=datain at the edge.
  - rd: dataout<=mem[addr] at the edge, i.e. valid the cycle after the strobe.
  - dataout holds its value otherwise, including throughout a sort.
- Priority in IDLE: start > wr > rd. The losing strobes are ignored in that cycle.
- While ready=0, wr, rd, start and desc are ignored.
- FSM states: IDLE, OUTER, INNER, ENDIN, SWAP_A, SWAP_B.
  - IDLE: on start -> OUTER; i<=0; mode<=desc; ready<=0.
  - OUTER (1 cycle): issue read mem[i]; j<=i+1; idx<=i.
  - INNER (DEPTH-1-i cycles):
    - Each cycle issues read mem[j] and compares the previously returned word against best.
    - The first INNER cycle loads best<=mem[i] and cur<=mem[i].
    - Then j increments; the cycle that issues j=DEPTH-1 goes -> ENDIN.
  - ENDIN (1 cycle): compare the last returned word.
    - If the final idx!=i -> SWAP_A.
    - Otherwise i<=i+1 and -> OUTER, or -> IDLE if i==DEPTH-2.
  - SWAP_A: mem[idx]<=cur.
  - SWAP_B: mem[i]<=best; then i<=i+1 and -> OUTER, or -> IDLE if i==DEPTH-2.
- Completion: on entry to IDLE from a sort, ready<=1 and done<=1 in the same edge; done clears on the following edge.
- Latency: ready is low for exactly 2(DEPTH-1) + DEPTH(DEPTH-1)/2 + 2S cycles, where S = number of swaps.
  - DEPTH=8: 42 + 2S cycles.
  - Counting starts at the edge that samples start.
- Only one RAM access per cycle internally: one read or one write, never both.

Optional Feature:
Macro SORT_SWAP_CNT_EN.
- Defined:
  - Adds output port swap_cnt, width $clog2(DEPTH), holding the swap count S of the last sort.
  - Cleared to 0 by rst and on start acceptance; increments on each SWAP_B.
  - Holds its value after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. DEPTH=8, WIDTH=8, load 1..8, start desc=0 -> ready low 42 cycles, done pulse, readback 1..8, swap_cnt=0.
2. Load 8,7,6,5,4,3,2,1, start desc=0 -> ready low 50 cycles (S=4), readback 1..8, swap_cnt=4.
3. Load 3,9,3,0,255,9,1,0, start desc=1 -> readback 255,9,9,3,3,1,0,0; duplicates never swapped with each other.
4. During sort pulse wr addr=0 datain=0xAA, rd, and start with desc toggled -> no effect; result and dataout are unchanged.
5. Assert rst 10 cycles into a sort -> next cycle ready=1, done=0, dataout=0; a new start completes a correct sort.
6. WIDTH=16, DEPTH=4, load 0x8000,0x0001,0xFFFF,0x7FFF asc -> readback 0x0001,0x7FFF,0x8000,0xFFFF (unsigned); same cycle start+wr in IDLE -> write dropped, sort runs.
